// File: rtl/dkong3_bg_fetch.sv
// Background tilemap fetch and pixel serializer.
// Each 8-pixel tile slot fetches the next column's tile code from tilemap
// VRAM, then both tile-ROM bitplanes and the colour PROM nibble. At the
// 7->0 pixel boundary the fetched tile is loaded into the serializer, so the
// pixels and palette stay aligned with the column being displayed.
module dkong3_bg_fetch #(
  parameter int COL_AHEAD = 1
) (
  input  logic        I_CLK,
  input  logic        I_RST_n,
  input  logic        I_CE_PIX,
  input  logic [9:0]  I_H_CNT,
  input  logic [7:0]  I_VF_CNT,
  input  logic        I_C_BLANKn,
  input  logic        I_HFLIP,
  input  logic        I_BANK,
  output logic [9:0]  O_VRAM_AB,
  input  logic [7:0]  I_VRAM_DB,
  output logic [11:0] O_ROM_AB,
  input  logic [7:0]  I_ROM_D0,
  input  logic [7:0]  I_ROM_D1,
  output logic [7:0]  O_COL_AB,
  input  logic [3:0]  I_COL_DB,
  output logic [1:0]  O_PIX,
  output logic [3:0]  O_PAL
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CODE  = 2'd1,
    S_DATA  = 2'd2,
    S_READY = 2'd3
  } state_t;

  state_t      state_q;
  state_t      state_d;

  logic [2:0]  px;
  logic [4:0]  col;
  logic [4:0]  ncol;
  logic        unused_h;

  // Sequencer strobes, each a single I_CLK wide (qualified by I_CE_PIX).
  logic        do_vram;
  logic        do_rom;
  logic        do_capture;
  logic        do_load;

  logic [9:0]  vram_ab_q;
  logic [11:0] rom_ab_q;
  logic [7:0]  col_ab_q;
  logic [4:0]  ncol_q;

  logic [7:0]  hold0_q;
  logic [7:0]  hold1_q;
  logic [3:0]  hold_pal_q;

  logic [7:0]  sh0_q;
  logic [7:0]  sh1_q;
  logic [3:0]  pal_q;
  logic        flip_q;
  logic        blank_n_q;

  logic [1:0]  pix_raw;

  assign px  = I_H_CNT[3:1];
  assign col = I_H_CNT[8:4];

  // The tile for the next column is fetched while the current one is shown;
  // the 5-bit add wraps column 31 back to 0.
  assign ncol = col + 5'(COL_AHEAD);

  // The half-pixel bit and the top count bit play no part in tile fetching.
  assign unused_h = ^{I_H_CNT[9], I_H_CNT[0]};

  // Sequencer state register.
  // NOTE: sequential logic uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others; blocking here would create order-dependent
  // shortcuts between registers.
  always_ff @(posedge I_CLK or negedge I_RST_n) begin
    if (!I_RST_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state: px==0 always (re)starts a fetch, even mid-sequence after a
  // counter jump; otherwise a state waits for its own trigger pixel.
  always_comb begin
    // NOTE: default first, so every path assigns state_d and no latch forms.
    state_d = state_q;
    if (I_CE_PIX) begin
      if (px == 3'd0) begin
        state_d = S_CODE;
      end else begin
        case (state_q)
          S_CODE:  if (px == 3'd2) state_d = S_DATA;
          S_DATA:  if (px == 3'd4) state_d = S_READY;
          S_READY: if (px == 3'd7) state_d = S_IDLE;
          default: state_d = state_q;
        endcase
      end
    end
  end

  // Output decode: one strobe per sequencer action.
  always_comb begin
    do_vram    = I_CE_PIX && (px == 3'd0);
    do_rom     = I_CE_PIX && (px == 3'd2) && (state_q == S_CODE);
    do_capture = I_CE_PIX && (px == 3'd4) && (state_q == S_DATA);
    do_load    = I_CE_PIX && (px == 3'd7) && (state_q == S_READY);
  end

  // Memory address registers; each holds its value between updates.
  always_ff @(posedge I_CLK or negedge I_RST_n) begin
    if (!I_RST_n) begin
      vram_ab_q <= '0;
      ncol_q    <= '0;
      rom_ab_q  <= '0;
      col_ab_q  <= '0;
    end else begin
      if (do_vram) begin
        vram_ab_q <= {I_VF_CNT[7:3], ncol};
        ncol_q    <= ncol;
      end
      if (do_rom) begin
        // The tile code comes straight from VRAM; this register keeps it.
        rom_ab_q <= {I_BANK, I_VRAM_DB, I_VF_CNT[2:0]};
        col_ab_q <= {I_VF_CNT[7:5], ncol_q};
      end
    end
  end

  // Holding registers: capture bitplanes and palette well after the address.
  always_ff @(posedge I_CLK or negedge I_RST_n) begin
    if (!I_RST_n) begin
      hold0_q    <= '0;
      hold1_q    <= '0;
      hold_pal_q <= '0;
    end else if (do_capture) begin
      hold0_q    <= I_ROM_D0;
      hold1_q    <= I_ROM_D1;
      hold_pal_q <= I_COL_DB;
    end
  end

  // Serializer: load at the tile boundary (freezing the flip direction for
  // the whole tile), otherwise shift one pixel per CE with zero fill.
  always_ff @(posedge I_CLK or negedge I_RST_n) begin
    if (!I_RST_n) begin
      sh0_q  <= '0;
      sh1_q  <= '0;
      pal_q  <= '0;
      flip_q <= 1'b0;
    end else if (do_load) begin
      sh0_q  <= hold0_q;
      sh1_q  <= hold1_q;
      pal_q  <= hold_pal_q;
      flip_q <= I_HFLIP;
    end else if (I_CE_PIX) begin
      if (flip_q) begin
        sh0_q <= {1'b0, sh0_q[7:1]};
        sh1_q <= {1'b0, sh1_q[7:1]};
      end else begin
        sh0_q <= {sh0_q[6:0], 1'b0};
        sh1_q <= {sh1_q[6:0], 1'b0};
      end
    end
  end

  // Blank is pixel-registered so it lines up with the serializer output.
  always_ff @(posedge I_CLK or negedge I_RST_n) begin
    if (!I_RST_n)      blank_n_q <= 1'b0;
    else if (I_CE_PIX) blank_n_q <= I_C_BLANKn;
  end

  assign pix_raw = flip_q ? {sh1_q[0], sh0_q[0]} : {sh1_q[7], sh0_q[7]};

  assign O_VRAM_AB = vram_ab_q;
  assign O_ROM_AB  = rom_ab_q;
  assign O_COL_AB  = col_ab_q;
  assign O_PIX     = blank_n_q ? pix_raw : 2'b00;
  assign O_PAL     = blank_n_q ? pal_q   : 4'h0;

endmodule

// File: doc/dkong3_bg_fetch.md
# dkong3_bg_fetch

Background tilemap fetch and pixel serializer. Sits directly downstream of the H/V counter. Consumes the horizontal count, the flip-adjusted vertical count and the composite blank. Each 8-pixel tile slot it runs a fixed fetch sequence (tilemap VRAM, then tile-ROM bitplanes and colour PROM) for the next column, and shifts out 2-bit pixels plus a 4-bit palette, aligned to the current column for the colour mixer.

## Interface
Parameters:
- `COL_AHEAD`, default 1: column look-ahead for the fetch. The only supported value is 1.

Ports:
- `I_CLK`, in, 1: 24.576 MHz system clock.
- `I_RST_n`, in, 1: reset, asynchronous, active-low.
- `I_CE_PIX`, in, 1: one-`I_CLK` pixel strobe, one per pixel (6.144 MHz).
- `I_H_CNT`, in, 10: horizontal count. Bit 0 is 1/2H. Pixel-in-tile `px` = `I_H_CNT[3:1]`. Column `col` = `I_H_CNT[8:4]`.
- `I_VF_CNT`, in, 8: flip-adjusted vertical count. Row = `[7:3]`, line-in-tile = `[2:0]`.
- `I_C_BLANKn`, in, 1: composite blank, active-low.
- `I_HFLIP`, in, 1: reverse serializer direction.
- `I_BANK`, in, 1: tile ROM bank select.
- `O_VRAM_AB`, out, 10: tilemap address.
- `I_VRAM_DB`, in, 8: tile code. Valid 1 `I_CLK` after the address.
- `O_ROM_AB`, out, 12: tile ROM address.
- `I_ROM_D0`, in, 8: bitplane 0.
- `I_ROM_D1`, in, 8: bitplane 1. Both planes are valid 1 `I_CLK` after the address.
- `O_COL_AB`, out, 8: colour PROM address.
- `I_COL_DB`, in, 4: palette. Valid 1 `I_CLK` after the address.
- `O_PIX`, out, 2: background pixel index.
- `O_PAL`, out, 4: palette for `O_PIX`.

## Operation
- `ncol` = `col + 1`, 5-bit wrap: column 31 wraps to 0.
- The fetch sequencer is keyed to `px` and advances only on `I_CE_PIX`. States and transitions:
  - `S_IDLE`: on CE with `px==0`, drive `O_VRAM_AB = {I_VF_CNT[7:3], ncol}` and latch `ncol` → `S_CODE`.
  - `S_CODE`: on CE with `px==2`:
    - latch `code = I_VRAM_DB`;
    - drive `O_ROM_AB = {I_BANK, code, I_VF_CNT[2:0]}`;
    - drive `O_COL_AB = {I_VF_CNT[7:5], latched ncol}`;
    - → `S_DATA`.
  - `S_DATA`: on CE with `px==4`, latch `I_ROM_D0`, `I_ROM_D1` and `I_COL_DB` into holding registers → `S_READY`.
  - `S_READY`: on CE with `px==7`, transfer holding registers into the shift registers and the palette register → `S_IDLE`.
- Hold rule: in any state, a CE whose `px` does not match the state's trigger value holds the current state.
- Resync: if `px==0` arrives while the sequencer is not in `S_IDLE` (counter jump or reload), the sequencer restarts at `S_IDLE`'s action that same CE. Holding registers are not transferred.
- Serializer: on every CE that is not a load, shift by one bit.
  - `I_HFLIP=0`: MSB first, shift left, zero fill.
  - `I_HFLIP=1`: LSB first, shift right, zero fill.
  - `O_PIX = {plane1_bit, plane0_bit}` from the current output end.
- Flip timing: `I_HFLIP` is sampled at load time and held for the whole tile. A mid-tile change takes effect at the next load.
- Blank: `I_C_BLANKn` is registered on CE. While the registered value is low, `O_PIX=0` and `O_PAL=0`. Fetching continues during blank, so the first visible tile is already loaded.
- Address outputs are registered and hold their last value between updates.

## Timing
- Reset values: every output is 0. Sequencer is in `S_IDLE`. Shift, holding and palette registers are 0.
- Memory latency: exactly 1 `I_CLK` for each memory. At least 8 `I_CLK` (2 CEs) separate each address from its data capture, giving margin.
- Alignment: the tile for column c is fetched during column c−1 and loaded at the CE where `px` 7→0. It appears on `O_PIX`/`O_PAL` in the `I_CLK` after that CE. Latency from `I_H_CNT` to pixel is 1 `I_CLK`.
- Simultaneous load and blank change: the load still occurs; blank masks only the outputs.
- Reset mid-fetch: all state clears asynchronously. After release, the first valid tile appears after the next complete `px` 0→7 sequence.

## Test plan
- VRAM[row 0, col 1] = 0x5A, ROM plane0 = 0xF0, plane1 = 0xCC, PROM = 0x9, line 0, no flip → during column 1, `O_PIX` sequence is 3,3,1,1,2,2,0,0 and `O_PAL` = 9.
- Same setup with `I_HFLIP=1` → sequence is 0,0,2,2,1,1,3,3. Toggling `I_HFLIP` at px=3 leaves the current tile's sequence unchanged.
- `col`=31 → `O_VRAM_AB` = {row, 5'd0} (wrap).
- `I_VF_CNT`=0x2D, code=0x80, `I_BANK`=1 → `O_ROM_AB` = 0xC05, `O_VRAM_AB` = 0x0A0 | ncol.
- `I_C_BLANKn` low for a whole tile → `O_PIX`=0 and `O_PAL`=0. The first CE after blank ends shows the correct fetched pixel.
- Assert `I_RST_n` at px=3 → all outputs are 0 immediately. After release, the first correct tile appears after the next px 0→7 sequence. Jumping `I_H_CNT` to px=0 while in `S_DATA` restarts the fetch with no stale load.
